// File: rtl/tile_serializer_pkg.sv
// tile_pkg: shared constants, types and helpers for the tile serializer.
// Used by tile_serializer, tile_serializer_if and tile_lane_pick.
// The optional zero-skip feature is enabled by TILE_SERIALIZER_SKIP_ZERO_EN.
package tile_pkg;

    localparam int ELEM_W   = 8;
    localparam int NUM_ELEM = 16;
    localparam int IDX_W    = 4;
    localparam int TILE_W   = ELEM_W * NUM_ELEM;

    typedef logic [TILE_W-1:0]   tile_t;
    typedef logic [ELEM_W-1:0]   elem_t;
    typedef logic [IDX_W-1:0]    idx_t;
    typedef logic [NUM_ELEM-1:0] mask_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam idx_t LAST_IDX = idx_t'(NUM_ELEM - 1);

    // Extract lane idx from a packed tile (lane i lives at bits [i*ELEM_W +: ELEM_W]).
    function automatic elem_t lane_slice(input tile_t tile, input idx_t idx);
        return tile[int'(idx)*ELEM_W +: ELEM_W];
    endfunction

    // One bit per lane, set when that lane holds a nonzero element.
    function automatic mask_t nonzero_mask(input tile_t tile);
        mask_t m;
        m = '0;
        for (int i = 0; i < NUM_ELEM; i++) begin
            m[i] = |tile[i*ELEM_W +: ELEM_W];
        end
        return m;
    endfunction

endpackage

// File: rtl/tile_serializer_if.sv
// tile_serializer_if: tile-in / beat-out handshake bundle.
// slave = the serializer's view, master = the producer/consumer environment.
// Feature macro relevant to users of this bus: TILE_SERIALIZER_SKIP_ZERO_EN.
interface tile_serializer_if;
    import tile_pkg::*;

    tile_t s_tile;
    logic  s_valid;
    logic  s_ready;
    elem_t m_data;
    idx_t  m_idx;
    logic  m_last;
    logic  m_valid;
    logic  m_ready;

    modport master (
        output s_tile, s_valid, m_ready,
        input  s_ready, m_data, m_idx, m_last, m_valid
    );

    modport slave (
        input  s_tile, s_valid, m_ready,
        output s_ready, m_data, m_idx, m_last, m_valid
    );

endinterface

// File: rtl/tile_lane_pick.sv
// tile_lane_pick: priority encoder over a pending-lane mask.
// Returns the lowest pending lane, whether any lane is pending, whether that
// lane is the only one left, and the mask with that lane removed.
// Instantiated only when TILE_SERIALIZER_SKIP_ZERO_EN is defined.
module tile_lane_pick
    import tile_pkg::*;
(
    input  mask_t i_mask,
    output idx_t  o_idx,
    output logic  o_any,
    output logic  o_last,
    output mask_t o_rest
);

    // Lowest set bit wins; scanning downward lets the last hit be the lowest.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int i = NUM_ELEM - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx = idx_t'(i);
                o_any = 1'b1;
            end
        end
    end

    // Remove the chosen lane; it is the last one when nothing remains.
    always_comb begin
        o_rest = '0;
        o_last = 1'b0;
        if (o_any) begin
            o_rest = i_mask & ~(mask_t'(1) << o_idx);
            o_last = (o_rest == '0);
        end
    end

endmodule

// File: rtl/tile_serializer.sv
// tile_serializer: captures one packed 4x4 tile and streams it out one element
// per beat with its lane index, with back-pressure and back-to-back tiles.
// Optional macro TILE_SERIALIZER_SKIP_ZERO_EN: emit only nonzero lanes (an
// all-zero tile emits a single zero beat on the highest lane index).
//
// state | meaning
// IDLE  | no tile held, s_ready=1, m_valid=0
// SEND  | tile held, m_valid=1, current lane on m_data/m_idx
module tile_serializer
    import tile_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    tile_serializer_if.slave bus
);

    state_t r_state;
    tile_t  r_tile;
    elem_t  r_data;
    idx_t   r_idx;
    logic   r_last;
    logic   r_valid;

    logic   w_beat_acc;
    logic   w_s_ready;
    logic   w_capture;

    elem_t  w_first_data;
    idx_t   w_first_idx;
    logic   w_first_last;
    idx_t   w_next_idx;
    logic   w_next_last;
    elem_t  w_next_data;

    assign w_beat_acc = r_valid && bus.m_ready;
    // A new tile is taken when idle, or exactly as the final beat leaves.
    assign w_s_ready  = !rst && ((r_state == IDLE) ||
                                 ((r_state == SEND) && w_beat_acc && r_last));
    assign w_capture  = bus.s_valid && w_s_ready;

`ifdef TILE_SERIALIZER_SKIP_ZERO_EN
    mask_t r_mask;
    mask_t w_cap_mask;
    idx_t  w_cap_idx;
    logic  w_cap_any;
    logic  w_cap_last;
    mask_t w_cap_rest;
    idx_t  w_nxt_idx;
    logic  w_nxt_any;
    logic  w_nxt_last;
    mask_t w_nxt_rest;

    assign w_cap_mask = nonzero_mask(bus.s_tile);

    tile_lane_pick u_pick_cap (
        .i_mask (w_cap_mask),
        .o_idx  (w_cap_idx),
        .o_any  (w_cap_any),
        .o_last (w_cap_last),
        .o_rest (w_cap_rest)
    );

    tile_lane_pick u_pick_nxt (
        .i_mask (r_mask),
        .o_idx  (w_nxt_idx),
        .o_any  (w_nxt_any),
        .o_last (w_nxt_last),
        .o_rest (w_nxt_rest)
    );

    // All-zero tile still produces one closing beat so the consumer sees m_last.
    always_comb begin
        w_first_idx  = LAST_IDX;
        w_first_data = '0;
        w_first_last = 1'b1;
        if (w_cap_any) begin
            w_first_idx  = w_cap_idx;
            w_first_data = lane_slice(bus.s_tile, w_cap_idx);
            w_first_last = w_cap_last;
        end
    end

    // r_mask is never empty while a non-last beat is showing, so w_nxt_any is implied.
    always_comb begin
        w_next_idx  = w_nxt_idx;
        w_next_last = w_nxt_last && w_nxt_any;
    end
`else
    // Plain sequential walk over every lane.
    always_comb begin
        w_first_idx  = '0;
        w_first_data = lane_slice(bus.s_tile, '0);
        w_first_last = (LAST_IDX == '0);
        w_next_idx   = r_idx + idx_t'(1);
        w_next_last  = (w_next_idx == LAST_IDX);
    end
`endif

    assign w_next_data = lane_slice(r_tile, w_next_idx);

    // FSM, tile register and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_tile  <= '0;
            r_data  <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
`ifdef TILE_SERIALIZER_SKIP_ZERO_EN
            r_mask  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_capture) begin
                        r_tile  <= bus.s_tile;
                        r_data  <= w_first_data;
                        r_idx   <= w_first_idx;
                        r_last  <= w_first_last;
                        r_valid <= 1'b1;
                        r_state <= SEND;
`ifdef TILE_SERIALIZER_SKIP_ZERO_EN
                        r_mask  <= w_cap_rest;
`endif
                    end
                end
                SEND: begin
                    if (w_beat_acc) begin
                        if (r_last) begin
                            if (w_capture) begin
                                r_tile  <= bus.s_tile;
                                r_data  <= w_first_data;
                                r_idx   <= w_first_idx;
                                r_last  <= w_first_last;
`ifdef TILE_SERIALIZER_SKIP_ZERO_EN
                                r_mask  <= w_cap_rest;
`endif
                            end else begin
                                r_valid <= 1'b0;
                                r_last  <= 1'b0;
                                r_state <= IDLE;
                            end
                        end else begin
                            r_data <= w_next_data;
                            r_idx  <= w_next_idx;
                            r_last <= w_next_last;
`ifdef TILE_SERIALIZER_SKIP_ZERO_EN
                            r_mask <= w_nxt_rest;
`endif
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.m_data  = r_data;
    assign bus.m_idx   = r_idx;
    assign bus.m_last  = r_last;
    assign bus.m_valid = r_valid;

endmodule

// File: tb/tb_tile_serializer.sv
// tb_tile_serializer: directed self-checking bench for tile_serializer.
// Zero-skip cases are compiled in when TILE_SERIALIZER_SKIP_ZERO_EN is defined.
module tb_tile_serializer;
    import tile_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    tile_serializer_if bus();

    tile_serializer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int q_data[$];
    int q_idx[$];
    int q_last[$];
    int q_sr[$];
    int q_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic tile_t ramp_tile();
        tile_t t;
        t = '0;
        for (int i = 0; i < NUM_ELEM; i++) t[i*ELEM_W +: ELEM_W] = 8'(i + 1);
        return t;
    endfunction

    function automatic tile_t fill_tile(input logic [7:0] v);
        tile_t t;
        t = '0;
        for (int i = 0; i < NUM_ELEM; i++) t[i*ELEM_W +: ELEM_W] = v;
        return t;
    endfunction

    // Offer a tile and wait (bounded) until s_ready so the next posedge accepts it.
    task automatic send_tile(input tile_t t);
        int w;
        w = 0;
        @(negedge clk);
        bus.s_tile  = t;
        bus.s_valid = 1'b1;
        #1;
        while (!bus.s_ready && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("accept_wait", 32'(bus.s_ready), 32'd1);
    endtask

    // Collect n beats; optionally stall at one lane and optionally offer a follow-up tile.
    task automatic collect(input int n, input int stall_idx, input int stall_len,
                           input bit offer_next, input tile_t next_tile);
        int    cyc;
        int    stalled;
        bit    handed;
        elem_t held_d;
        idx_t  held_i;
        cyc = 0; stalled = 0; handed = 1'b0; held_d = '0; held_i = '0;
        q_data.delete(); q_idx.delete(); q_last.delete(); q_sr.delete(); q_cyc.delete();
        while (q_data.size() < n && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                if (offer_next) bus.s_tile = next_tile;
                else begin
                    bus.s_valid = 1'b0;
                    bus.s_tile  = '1;
                end
            end else if (handed) begin
                bus.s_valid = 1'b0;
                bus.s_tile  = '1;
            end
            if (stall_idx >= 0 && stalled < stall_len &&
                (stalled > 0 || (bus.m_valid && bus.m_idx == idx_t'(stall_idx)))) begin
                if (stalled == 0) begin
                    held_d = bus.m_data;
                    held_i = bus.m_idx;
                end else begin
                    chk("hold_valid", 32'(bus.m_valid), 32'd1);
                    chk("hold_data", 32'(bus.m_data), 32'(held_d));
                    chk("hold_idx", 32'(bus.m_idx), 32'(held_i));
                end
                bus.m_ready = 1'b0;
                stalled++;
            end else begin
                bus.m_ready = 1'b1;
            end
            #1;
            if (bus.m_valid && bus.m_ready) begin
                q_data.push_back(int'(bus.m_data));
                q_idx.push_back(int'(bus.m_idx));
                q_last.push_back(int'(bus.m_last));
                q_sr.push_back(int'(bus.s_ready));
                q_cyc.push_back(cyc);
            end
            if (offer_next && bus.s_valid && bus.s_ready) handed = 1'b1;
        end
        chk("beat_count", 32'(q_data.size()), 32'(n));
    endtask

    initial begin
        bus.s_tile  = '0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_m_last",  32'(bus.m_last),  32'd0);
        chk("rst_m_data",  32'(bus.m_data),  32'd0);
        chk("rst_m_idx",   32'(bus.m_idx),   32'd0);
        chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
        rst = 1'b0;
        bus.m_ready = 1'b1;
        #1;
        chk("idle_s_ready", 32'(bus.s_ready), 32'd1);

        // 1: ramp tile, no back-pressure, s_tile scribbled after accept
        send_tile(ramp_tile());
        collect(16, -1, 0, 1'b0, '0);
        for (int k = 0; k < q_data.size(); k++) begin
            chk("t1_data", 32'(q_data[k]), 32'(k + 1));
            chk("t1_idx",  32'(q_idx[k]),  32'(k));
            chk("t1_last", 32'(q_last[k]), 32'(k == 15));
            chk("t1_sready", 32'(q_sr[k]), 32'(k == 15));
        end
        if (q_cyc.size() == 16) begin
            chk("t1_first_lat", 32'(q_cyc[0]),  32'd1);
            chk("t1_end_cyc",   32'(q_cyc[15]), 32'd16);
        end
        @(negedge clk);
        #1;
        chk("t1_idle_valid", 32'(bus.m_valid), 32'd0);
        chk("t1_idle_ready", 32'(bus.s_ready), 32'd1);

        // 2: 3-cycle stall at lane 2
        send_tile(ramp_tile());
        collect(16, 2, 3, 1'b0, '0);
        for (int k = 0; k < q_data.size(); k++) begin
            chk("t2_data", 32'(q_data[k]), 32'(k + 1));
            chk("t2_idx",  32'(q_idx[k]),  32'(k));
        end
        if (q_cyc.size() == 16) begin
            chk("t2_stall_cyc", 32'(q_cyc[2]),  32'd6);
            chk("t2_end_cyc",   32'(q_cyc[15]), 32'd19);
        end

        // 3: back-to-back 0xAA then 0x55
        send_tile(fill_tile(8'hAA));
        collect(32, -1, 0, 1'b1, fill_tile(8'h55));
        for (int k = 0; k < q_data.size(); k++) begin
            chk("t3_data", 32'(q_data[k]), (k < 16) ? 32'hAA : 32'h55);
            chk("t3_idx",  32'(q_idx[k]),  32'(k % 16));
            chk("t3_last", 32'(q_last[k]), 32'(k == 15 || k == 31));
            chk("t3_cyc",  32'(q_cyc[k]),  32'(k + 1));
        end
        @(negedge clk);
        #1;
        chk("t3_idle_valid", 32'(bus.m_valid), 32'd0);

        // 4: reset in mid-tile at lane 7
        send_tile(ramp_tile());
        begin
            int w;
            w = 0;
            @(negedge clk);
            bus.s_valid = 1'b0;
            bus.m_ready = 1'b1;
            #1;
            while (!(bus.m_valid && bus.m_idx == idx_t'(7)) && w < 50) begin
                @(negedge clk);
                #1;
                w++;
            end
            chk("t4_reach_idx7", 32'(bus.m_idx), 32'd7);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("t4_rst_valid", 32'(bus.m_valid), 32'd0);
        chk("t4_rst_last",  32'(bus.m_last),  32'd0);
        chk("t4_rst_idx",   32'(bus.m_idx),   32'd0);
        chk("t4_rst_ready", 32'(bus.s_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("t4_post_ready", 32'(bus.s_ready), 32'd1);
        send_tile(ramp_tile());
        collect(16, -1, 0, 1'b0, '0);
        if (q_data.size() == 16) begin
            chk("t4_first_idx",  32'(q_idx[0]),   32'd0);
            chk("t4_first_data", 32'(q_data[0]),  32'd1);
            chk("t4_last_idx",   32'(q_idx[15]),  32'd15);
            chk("t4_last_flag",  32'(q_last[15]), 32'd1);
            chk("t4_no_early_last", 32'(q_last[14]), 32'd0);
        end

`ifdef TILE_SERIALIZER_SKIP_ZERO_EN
        // 5: sparse tile, only lanes 3 and 9 nonzero
        begin
            tile_t t;
            t = '0;
            t[3*ELEM_W +: ELEM_W] = 8'h11;
            t[9*ELEM_W +: ELEM_W] = 8'h22;
            send_tile(t);
        end
        collect(2, -1, 0, 1'b0, '0);
        if (q_data.size() == 2) begin
            chk("t5_d0", 32'(q_data[0]), 32'h11);
            chk("t5_i0", 32'(q_idx[0]),  32'd3);
            chk("t5_l0", 32'(q_last[0]), 32'd0);
            chk("t5_d1", 32'(q_data[1]), 32'h22);
            chk("t5_i1", 32'(q_idx[1]),  32'd9);
            chk("t5_l1", 32'(q_last[1]), 32'd1);
            chk("t5_cyc", 32'(q_cyc[1]), 32'd2);
        end
        @(negedge clk);
        #1;
        chk("t5_idle_valid", 32'(bus.m_valid), 32'd0);

        // 6: all-zero tile collapses to one closing beat
        send_tile('0);
        collect(1, -1, 0, 1'b0, '0);
        if (q_data.size() == 1) begin
            chk("t6_data", 32'(q_data[0]), 32'd0);
            chk("t6_idx",  32'(q_idx[0]),  32'd15);
            chk("t6_last", 32'(q_last[0]), 32'd1);
        end
        @(negedge clk);
        #1;
        chk("t6_idle_valid", 32'(bus.m_valid), 32'd0);
`else
        // 6: all-zero tile streams every lane
        send_tile('0);
        collect(16, -1, 0, 1'b0, '0);
        for (int k = 0; k < q_data.size(); k++) begin
            chk("t6_data", 32'(q_data[k]), 32'd0);
            chk("t6_idx",  32'(q_idx[k]),  32'(k));
            chk("t6_last", 32'(q_last[k]), 32'(k == 15));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
